// File: rtl/sorter_sched_pkg.sv
// Shared constants for the sorter job scheduler: FSM state encoding and
// constellation (M) codes as seen on the sorter interface.
package sorter_sched_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GRANT   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [1:0] M_QPSK   = 2'b00;
    localparam logic [1:0] M_QAM16  = 2'b01;
    localparam logic [1:0] M_QAM64  = 2'b10;
    localparam logic [1:0] M_QAM256 = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: first set req bit scanning upward from rr_ptr.
// With SCHED_STRICT_PRIO_EN defined, requester 0 wins outright and the rest rotate.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   cand;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rotated;
    logic [IDX_W:0]       sum;
    logic                 found;

    always_comb begin
        cand  = req;
        found = 1'b0;
        sum   = '0;
        gnt   = '0;
        idx   = '0;
`ifdef SCHED_STRICT_PRIO_EN
        if (req[0]) begin
            found = 1'b1;
        end
        cand[0] = 1'b0;
`endif
        // Rotate so bit 0 of 'rotated' is the requester at rr_ptr.
        dbl     = {cand, cand};
        rotated = NUM_REQ'(dbl >> rr_ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            end
        end
        if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
        end
        if (found) begin
            idx = sum[IDX_W-1:0];
            for (int j = 0; j < NUM_REQ; j++) begin
                gnt[j] = (sum == (IDX_W+1)'(j));
            end
        end
    end

endmodule

// File: rtl/sorter_job_scheduler.sv
// Shares one constellation sorter among NUM_REQ requesters: arbitrate, run start burst,
// wait for done (with watchdog), ack. Optional macro: SCHED_STRICT_PRIO_EN.
module sorter_job_scheduler
    import sorter_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     req_m,
    input  logic [LEN_W*NUM_REQ-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       job_done,
    output logic                     sorter_start,
    output logic [1:0]               sorter_m,
    input  logic                     sorter_done,
    output logic                     busy,
    output logic                     err_timeout
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d, next_ptr;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               start_q, start_d;
    logic [1:0]         m_q, m_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [1:0]         sel_m;
    logic [LEN_W-1:0]   sel_len;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req),
        .rr_ptr (ptr_q),
        .gnt    (arb_gnt),
        .idx    (arb_idx)
    );

    always_comb begin
        sel_m   = '0;
        sel_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_m   = sel_m | req_m[2*i +: 2];
                sel_len = sel_len | req_len[LEN_W*i +: LEN_W];
            end
        end
    end

    assign next_ptr = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        start_d  = start_q;
        m_d      = m_q;
        busy_d   = busy_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d  = ST_GRANT;
                    winner_d = arb_idx;
                    gnt_d    = arb_gnt;
                    m_d      = sel_m;
                    cnt_d    = (sel_len == '0) ? LEN_W'(1) : sel_len;
                    busy_d   = 1'b1;
                end
            end
            ST_GRANT: begin
                state_d = ST_RUN;
                start_d = 1'b1;
            end
            ST_RUN: begin
                if (cnt_q == LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                    start_d = 1'b0;
                    wd_d    = '0;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_DRAIN: begin
                // A done arriving on the expiry cycle takes precedence over the watchdog.
                if (sorter_done) begin
                    state_d = ST_RELEASE;
                    done_d  = gnt_q;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = ST_RELEASE;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
`ifdef SCHED_STRICT_PRIO_EN
                if (winner_q != '0) begin
                    ptr_d = next_ptr;
                end
`else
                ptr_d = next_ptr;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                start_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            winner_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            wd_q     <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            start_q  <= 1'b0;
            m_q      <= M_QPSK;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            start_q  <= start_d;
            m_q      <= m_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign gnt          = gnt_q;
    assign job_done     = done_q;
    assign sorter_start = start_q;
    assign sorter_m     = m_q;
    assign busy         = busy_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_sorter_job_scheduler.sv
// Self-checking bench for sorter_job_scheduler: directed job table, hand-written reset
// sequence, and randomized jobs checked against a transaction-level arbitration model.
module tb_sorter_job_scheduler;

    localparam int NR = 4;
    localparam int LW = 8;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [2*NR-1:0]   req_m = '0;
    logic [LW*NR-1:0]  req_len = '0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     job_done;
    logic              sorter_start;
    logic [1:0]        sorter_m;
    logic              sorter_done = 1'b0;
    logic              busy;
    logic              err_timeout;

    int checks = 0;
    int failures = 0;
    int mptr = 0;

    typedef struct {
        logic [NR-1:0]    reqv;
        logic [2*NR-1:0]  mv;
        logic [LW*NR-1:0] lenv;
        int               delay;
        logic [NR-1:0]    exp_gnt;
        logic [1:0]       exp_m;
        int               exp_start;
    } vec_t;

    vec_t tbl[$];

    sorter_job_scheduler #(
        .NUM_REQ (NR),
        .LEN_W   (LW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_m        (req_m),
        .req_len      (req_len),
        .gnt          (gnt),
        .job_done     (job_done),
        .sorter_start (sorter_start),
        .sorter_m     (sorter_m),
        .sorter_done  (sorter_done),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NR-1:0] r, input logic [2*NR-1:0] m,
                                input logic [LW*NR-1:0] l, input int d,
                                input logic [NR-1:0] g, input logic [1:0] em, input int es);
        vec_t v;
        v.reqv = r; v.mv = m; v.lenv = l; v.delay = d;
        v.exp_gnt = g; v.exp_m = em; v.exp_start = es;
        return v;
    endfunction

    // Reference arbitration: first requesting index scanning upward from the pointer.
    function automatic int model_winner(input logic [NR-1:0] r, input int p);
`ifdef SCHED_STRICT_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic do_job(input logic [NR-1:0] reqv, input logic [2*NR-1:0] mv,
                          input logic [LW*NR-1:0] lenv, input int delay,
                          input logic [NR-1:0] exp_gnt, input logic [1:0] exp_m,
                          input int exp_start, input bit noisy);
        int n;
        int w;
        bit unstable;
        req = reqv; req_m = mv; req_len = lenv;
        tick();
        check("grant_onehot", gnt, exp_gnt);
        check("grant_busy", busy, 1);
        check("grant_start_low", sorter_start, 0);
        check("grant_m", sorter_m, exp_m);
        tick();
        n = 0;
        unstable = 0;
        while (sorter_start === 1'b1 && n < 400) begin
            n++;
            if (gnt !== exp_gnt || sorter_m !== exp_m) unstable = 1;
            if (noisy) sorter_done = 1'($urandom_range(0, 1));
            tick();
        end
        sorter_done = 1'b0;
        check("start_cycles", n, exp_start);
        check("run_stable", unstable, 0);
        if (delay >= 0) begin
            repeat (delay) tick();
            sorter_done = 1'b1;
            tick();
            sorter_done = 1'b0;
        end else begin
            n = 0;
            while (err_timeout !== 1'b1 && n < 200) begin
                n++;
                tick();
            end
            check("timeout_latency", n, TO);
        end
        check("job_done_pulse", job_done, exp_gnt);
        check("err_pulse", err_timeout, (delay < 0) ? 1 : 0);
        check("release_busy", busy, 1);
        check("release_gnt", gnt, exp_gnt);
        tick();
        check("after_job_done", job_done, 0);
        check("after_gnt", gnt, 0);
        check("after_busy", busy, 0);
        check("after_err", err_timeout, 0);
        check("m_held", sorter_m, exp_m);
        w = 0;
        for (int k = 0; k < NR; k++) if (exp_gnt[k]) w = k;
`ifdef SCHED_STRICT_PRIO_EN
        if (w != 0) mptr = (w + 1) % NR;
`else
        mptr = (w + 1) % NR;
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_job_done"}, job_done, 0);
        check({tag, "_start"}, sorter_start, 0);
        check({tag, "_m"}, sorter_m, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err_timeout, 0);
    endtask

    initial begin
`ifdef SCHED_STRICT_PRIO_EN
        tbl.push_back(mk(4'b1011, 8'b00_00_00_01, 32'h00000003, 2, 4'b0001, 2'b01, 3));
        tbl.push_back(mk(4'b1011, 8'b10_00_11_01, 32'h01000202, 0, 4'b0001, 2'b01, 2));
        tbl.push_back(mk(4'b1011, 8'b10_00_11_01, 32'h01000202, 0, 4'b0001, 2'b01, 2));
        tbl.push_back(mk(4'b1010, 8'b10_00_11_01, 32'h01000202, 0, 4'b0010, 2'b11, 2));
        tbl.push_back(mk(4'b1010, 8'b10_00_11_01, 32'h01000202, 0, 4'b1000, 2'b10, 1));
        tbl.push_back(mk(4'b0001, 8'b00_00_00_10, 32'h00000004, -1, 4'b0001, 2'b10, 4));
        tbl.push_back(mk(4'b0110, 8'b00_01_00_00, 32'h00000000, 1, 4'b0010, 2'b00, 1));
        tbl.push_back(mk(4'b0111, 8'b00_01_11_10, 32'h00000000, 63, 4'b0001, 2'b10, 1));
`else
        tbl.push_back(mk(4'b0001, 8'b00_00_00_01, 32'h00000003, 2, 4'b0001, 2'b01, 3));
        tbl.push_back(mk(4'b1111, 8'b11_10_01_00, 32'h02020202, 0, 4'b0010, 2'b01, 2));
        tbl.push_back(mk(4'b1111, 8'b11_10_01_00, 32'h02020202, 0, 4'b0100, 2'b10, 2));
        tbl.push_back(mk(4'b1111, 8'b11_10_01_00, 32'h02020202, 0, 4'b1000, 2'b11, 2));
        tbl.push_back(mk(4'b1111, 8'b11_10_01_00, 32'h02020202, 0, 4'b0001, 2'b00, 2));
        tbl.push_back(mk(4'b0100, 8'b00_11_00_00, 32'h00000000, 1, 4'b0100, 2'b11, 1));
        tbl.push_back(mk(4'b0010, 8'b00_00_10_00, 32'h00000500, -1, 4'b0010, 2'b10, 5));
        tbl.push_back(mk(4'b1001, 8'b01_00_00_11, 32'h04000001, 63, 4'b1000, 2'b01, 4));
        tbl.push_back(mk(4'b1001, 8'b01_00_00_11, 32'h04000001, 0, 4'b0001, 2'b11, 1));
        tbl.push_back(mk(4'b0110, 8'b00_10_01_00, 32'h0000FF00, 1, 4'b0010, 2'b01, 255));
`endif

        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b1;
        mptr = 0;

        foreach (tbl[i]) begin
            do_job(tbl[i].reqv, tbl[i].mv, tbl[i].lenv, tbl[i].delay,
                   tbl[i].exp_gnt, tbl[i].exp_m, tbl[i].exp_start, 1'b0);
        end

        for (int t = 0; t < 40; t++) begin
            logic [NR-1:0]    r;
            logic [2*NR-1:0]  m;
            logic [LW*NR-1:0] l;
            int w;
            int d;
            int ln;
            r = NR'($urandom_range(1, (1 << NR) - 1));
            m = (2*NR)'($urandom);
            for (int k = 0; k < NR; k++) l[LW*k +: LW] = LW'($urandom_range(0, 12));
            d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8));
            w = model_winner(r, mptr);
            ln = int'(l[LW*w +: LW]);
            do_job(r, m, l, d, NR'(1 << w), m[2*w +: 2], (ln == 0) ? 1 : ln, 1'b1);
        end

        // Abort a job mid-RUN after steering the pointer away from 0.
        do_job(4'b0010, 8'b00_00_01_00, 32'h00000100, 0, 4'b0010, 2'b01, 1, 1'b0);
        req = 4'b0001; req_m = 8'b00_00_00_10; req_len = 32'h0000000A;
        repeat (4) tick();
        check("abort_in_run", sorter_start, 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        req = 4'b0110; req_m = 8'b00_11_01_00; req_len = 32'h00020300;
        repeat (2) tick();
        check_all_zero("held_reset");
        rst = 1'b1;
        mptr = 0;
        do_job(4'b0110, 8'b00_11_01_00, 32'h00020300, 1, 4'b0010, 2'b01, 3, 1'b0);
        do_job(4'b0100, 8'b00_11_01_00, 32'h00020300, 0, 4'b0100, 2'b11, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sorter_job_scheduler.md
Name: sorter_job_scheduler

Overview:
- Shares one constellation sorter (start/M/done interface) among NUM_REQ V2V channel requesters.
- Round-robin arbitration; per job: latches requester's modulation index M and burst length, holds sorter start high for exactly that many cycles, then waits for sorter done, acks requester.
- Sits between channel front-ends and the sorter control unit; watchdog recovers from a sorter that never signals done.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LEN_W, 8, width of per-request burst length
- TIMEOUT, 64, max cycles waited for sorter_done after start drops

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester job request, level
- req_m  in  2*NUM_REQ  packed M per requester (slice i = bits 2i+1:2i); 00 QPSK, 01 QAM16, 10 QAM64, 11 QAM256
- req_len  in  LEN_W*NUM_REQ  packed burst length (cycles of sorter start)
- gnt  out  NUM_REQ  one-hot grant, held for the whole job
- job_done  out  NUM_REQ  one-cycle ack pulse to granted requester
- sorter_start  out  1  start to sorter
- sorter_m  out  2  M to sorter, stable during whole job
- sorter_done  in  1  sorter completion
- busy  out  1  high in any state except IDLE
- err_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, counters 0. Reset mid-job aborts immediately; no job_done issued.
- All outputs registered.
- States: IDLE, GRANT, RUN, DRAIN, RELEASE.
- IDLE: if any req bit set, pick winner → GRANT. Winner = first set bit scanning upward (with wrap) from rr pointer.
  - Latch winner index, its req_m slice, its req_len slice; len 0 is coerced to 1.
  - gnt[winner] high from the same edge.
- GRANT (1 cycle): sorter_m driven with latched M; sorter_start still 0 → RUN.
- RUN: sorter_start=1 for exactly len cycles (down-counter); sorter_done ignored → DRAIN.
- DRAIN: sorter_start=0; watchdog counts from 0.
  - On sorter_done=1 → RELEASE.
  - If watchdog reaches TIMEOUT-1 with no done: err_timeout pulse → RELEASE.
- RELEASE (1 cycle): job_done[winner] pulse; gnt cleared at next edge; rr pointer = (winner+1) mod NUM_REQ; busy drops → IDLE.
- Minimum gap between jobs: 1 IDLE cycle.
- Req deasserted mid-job: job runs to completion; req and req_m/req_len sampled only in IDLE.
- sorter_done asserted in IDLE/GRANT/RUN: ignored.
- Timeout and sorter_done in the same cycle: done wins, no err pulse.
- sorter_m holds its value after the job until the next GRANT; 00 after reset.

Optional Feature:
- Macro SCHED_STRICT_PRIO_EN.
- Defined: requester 0 always wins if its req is set; remaining requesters use round-robin among themselves. rr pointer is not updated when requester 0 wins.
- Undefined: pure round-robin over all requesters.

Decomposition:
- Package sorter_sched_pkg: state encoding constants and M code constants (M_QPSK, M_QAM16, M_QAM64, M_QAM256).
- Sub-module rr_arbiter: combinational winner select from req and rr pointer; emits one-hot grant and index. Holds the SCHED_STRICT_PRIO_EN variant.

Test Plan:
- Reset, then req=0001, req_m0=01, len0=3 → gnt=0001, sorter_m=01, sorter_start high exactly 3 cycles.
  - Then done after 2 cycles → job_done=0001 for 1 cycle; busy low next cycle.
- req=1111 held, done returned promptly each job → grant order 0001,0010,0100,1000,0001.
- len=0 → sorter_start high exactly 1 cycle.
- sorter_done never asserted, TIMEOUT=64 → err_timeout pulse 64 cycles after start drops; job_done still pulses; next requester served.
- Reset asserted during RUN → all outputs 0 asynchronously; after release, req=0100 served first with rr pointer 0.
- With SCHED_STRICT_PRIO_EN, req=1011 held → grants 0001 repeatedly while req0 high; drop req0 → 0010 then 1000.
